// File: rtl/matrix_ctrl_pkg.sv
// Shared types and helpers for the matrix access controller.
//   ctrl_state_e : controller FSM states
//   addr_width() : address width for a given depth, never less than 1 bit
package matrix_ctrl_pkg;

   typedef enum logic [2:0] {
      S_EMPTY,
      S_FILL,
      S_IDLE,
      S_ROW_WAIT,
      S_COL_WAIT
   } ctrl_state_e;

   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? int'($clog2(depth)) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a registered priority pointer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i[1:0]    : request vector (bit 0 has priority after reset)
//   gnt_o[1:0]    : one-hot grant (combinational); the pointer moves to the
//                   other requester after every grant
module rr_arbiter2 (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   // ptr_q == 0: requester 0 wins a tie; ptr_q == 1: requester 1 wins a tie
   logic ptr_q, ptr_d;

   always_comb begin
      gnt_o = 2'b00;
      if (req_i[0] && (!req_i[1] || !ptr_q)) begin
         gnt_o[0] = 1'b1;
      end else if (req_i[1]) begin
         gnt_o[1] = 1'b1;
      end

      ptr_d = ptr_q;
      if (gnt_o[0]) begin
         ptr_d = 1'b1;
      end else if (gnt_o[1]) begin
         ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/matrix_access_ctrl.sv
// Owns one matrix storage instance: loads it from a row-major element stream,
// then serves row and column reads for two requesters, one access at a time.
//   clk, rst_n            : clock, asynchronous active-low reset
//   fill_start            : pulse, start a full load (honoured in S_EMPTY/S_IDLE)
//   in_valid/in_ready/in_data : element stream, row-major
//   loaded                : matrix holds a complete load
//   rreq_* / rrsp_*       : row request handshake and one-cycle response pulse
//   creq_* / crsp_*       : column request handshake and one-cycle response pulse
//   m_row_* / m_col_*     : storage read ports (addr_ready pulse, then valid)
//   m_write_*             : storage element write port
module matrix_access_ctrl
   import matrix_ctrl_pkg::*;
#(
   parameter int unsigned  NUM_ROWS       = 5,
   parameter int unsigned  NUM_COLS       = 3,
   parameter int unsigned  SCALAR_BITS    = 32,
   localparam int unsigned ROW_ADDR_WIDTH = addr_width(NUM_ROWS),
   localparam int unsigned COL_ADDR_WIDTH = addr_width(NUM_COLS),
   localparam int unsigned ROW_SIZE       = NUM_COLS * SCALAR_BITS,
   localparam int unsigned COL_SIZE       = NUM_ROWS * SCALAR_BITS
) (
   input  logic                      clk,
   input  logic                      rst_n,

   input  logic                      fill_start,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SCALAR_BITS-1:0]    in_data,
   output logic                      loaded,

   input  logic                      rreq_valid,
   output logic                      rreq_ready,
   input  logic [ROW_ADDR_WIDTH-1:0] rreq_addr,
   output logic                      rrsp_valid,
   output logic                      rrsp_err,
   output logic [ROW_SIZE-1:0]       rrsp_data,

   input  logic                      creq_valid,
   output logic                      creq_ready,
   input  logic [COL_ADDR_WIDTH-1:0] creq_addr,
   output logic                      crsp_valid,
   output logic                      crsp_err,
   output logic [COL_SIZE-1:0]       crsp_data,

   output logic [ROW_ADDR_WIDTH-1:0] m_row_addr,
   output logic                      m_row_addr_ready,
   input  logic                      m_row_valid,
   input  logic [ROW_SIZE-1:0]       m_row_out,

   output logic [COL_ADDR_WIDTH-1:0] m_col_addr,
   output logic                      m_col_addr_ready,
   input  logic                      m_col_valid,
   input  logic [COL_SIZE-1:0]       m_col_out,

   output logic [ROW_ADDR_WIDTH-1:0] m_write_row_addr,
   output logic [COL_ADDR_WIDTH-1:0] m_write_col_addr,
   output logic [SCALAR_BITS-1:0]    m_write_data,
   output logic                      m_write_ready
);

   localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(NUM_ROWS - 1);
   localparam logic [COL_ADDR_WIDTH-1:0] LAST_COL = COL_ADDR_WIDTH'(NUM_COLS - 1);

   ctrl_state_e state_q, state_d;

   logic [ROW_ADDR_WIDTH-1:0] r_q, r_d;
   logic [COL_ADDR_WIDTH-1:0] c_q, c_d;
   logic                      loaded_q, loaded_d;

   logic                      wr_valid_q, wr_valid_d;
   logic [ROW_ADDR_WIDTH-1:0] wr_row_q, wr_row_d;
   logic [COL_ADDR_WIDTH-1:0] wr_col_q, wr_col_d;
   logic [SCALAR_BITS-1:0]    wr_data_q, wr_data_d;

   logic                      row_ar_q, row_ar_d;
   logic [ROW_ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
   logic                      col_ar_q, col_ar_d;
   logic [COL_ADDR_WIDTH-1:0] col_addr_q, col_addr_d;

   logic                      rrsp_valid_q, rrsp_valid_d;
   logic                      rrsp_err_q, rrsp_err_d;
   logic [ROW_SIZE-1:0]       rrsp_data_q, rrsp_data_d;
   logic                      crsp_valid_q, crsp_valid_d;
   logic                      crsp_err_q, crsp_err_d;
   logic [COL_SIZE-1:0]       crsp_data_q, crsp_data_d;

   logic       grant_en;
   logic [1:0] arb_req;
   logic [1:0] arb_gnt;
   logic       row_oob;
   logic       col_oob;

   // fill_start wins over a simultaneous request so a reload never races a read
   assign grant_en = (state_q == S_IDLE) && loaded_q && !fill_start;
   assign arb_req  = {creq_valid, rreq_valid} & {2{grant_en}};

   rr_arbiter2 u_arb (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .req_i  (arb_req),
      .gnt_o  (arb_gnt)
   );

   assign row_oob = 32'(rreq_addr) >= NUM_ROWS;
   assign col_oob = 32'(creq_addr) >= NUM_COLS;

   always_comb begin
      state_d      = state_q;
      r_d          = r_q;
      c_d          = c_q;
      loaded_d     = loaded_q;
      wr_valid_d   = 1'b0;
      wr_row_d     = wr_row_q;
      wr_col_d     = wr_col_q;
      wr_data_d    = wr_data_q;
      row_ar_d     = 1'b0;
      row_addr_d   = row_addr_q;
      col_ar_d     = 1'b0;
      col_addr_d   = col_addr_q;
      rrsp_valid_d = 1'b0;
      rrsp_err_d   = 1'b0;
      rrsp_data_d  = rrsp_data_q;
      crsp_valid_d = 1'b0;
      crsp_err_d   = 1'b0;
      crsp_data_d  = crsp_data_q;

      case (state_q)
         S_EMPTY: begin
            if (fill_start) begin
               state_d  = S_FILL;
               r_d      = '0;
               c_d      = '0;
               loaded_d = 1'b0;
            end
         end

         S_FILL: begin
            if (in_valid) begin
               wr_valid_d = 1'b1;
               wr_row_d   = r_q;
               wr_col_d   = c_q;
               wr_data_d  = in_data;
               if (c_q == LAST_COL) begin
                  c_d = '0;
                  if (r_q == LAST_ROW) begin
                     r_d      = '0;
                     loaded_d = 1'b1;
                     state_d  = S_IDLE;
                  end else begin
                     r_d = r_q + ROW_ADDR_WIDTH'(1);
                  end
               end else begin
                  c_d = c_q + COL_ADDR_WIDTH'(1);
               end
            end
         end

         S_IDLE: begin
            if (fill_start) begin
               state_d  = S_FILL;
               r_d      = '0;
               c_d      = '0;
               loaded_d = 1'b0;
            end else if (arb_gnt[0]) begin
               if (row_oob) begin
                  // Answered locally, storage is never touched
                  rrsp_valid_d = 1'b1;
                  rrsp_err_d   = 1'b1;
                  rrsp_data_d  = '0;
               end else begin
                  row_addr_d = rreq_addr;
                  row_ar_d   = 1'b1;
                  state_d    = S_ROW_WAIT;
               end
            end else if (arb_gnt[1]) begin
               if (col_oob) begin
                  crsp_valid_d = 1'b1;
                  crsp_err_d   = 1'b1;
                  crsp_data_d  = '0;
               end else begin
                  col_addr_d = creq_addr;
                  col_ar_d   = 1'b1;
                  state_d    = S_COL_WAIT;
               end
            end
         end

         S_ROW_WAIT: begin
            // valid during the addr_ready cycle belongs to no request of ours
            if (!row_ar_q && m_row_valid) begin
               rrsp_data_d  = m_row_out;
               rrsp_valid_d = 1'b1;
               state_d      = S_IDLE;
            end
         end

         S_COL_WAIT: begin
            if (!col_ar_q && m_col_valid) begin
               crsp_data_d  = m_col_out;
               crsp_valid_d = 1'b1;
               state_d      = S_IDLE;
            end
         end

         default: state_d = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_EMPTY;
         r_q          <= '0;
         c_q          <= '0;
         loaded_q     <= 1'b0;
         wr_valid_q   <= 1'b0;
         wr_row_q     <= '0;
         wr_col_q     <= '0;
         wr_data_q    <= '0;
         row_ar_q     <= 1'b0;
         row_addr_q   <= '0;
         col_ar_q     <= 1'b0;
         col_addr_q   <= '0;
         rrsp_valid_q <= 1'b0;
         rrsp_err_q   <= 1'b0;
         rrsp_data_q  <= '0;
         crsp_valid_q <= 1'b0;
         crsp_err_q   <= 1'b0;
         crsp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         r_q          <= r_d;
         c_q          <= c_d;
         loaded_q     <= loaded_d;
         wr_valid_q   <= wr_valid_d;
         wr_row_q     <= wr_row_d;
         wr_col_q     <= wr_col_d;
         wr_data_q    <= wr_data_d;
         row_ar_q     <= row_ar_d;
         row_addr_q   <= row_addr_d;
         col_ar_q     <= col_ar_d;
         col_addr_q   <= col_addr_d;
         rrsp_valid_q <= rrsp_valid_d;
         rrsp_err_q   <= rrsp_err_d;
         rrsp_data_q  <= rrsp_data_d;
         crsp_valid_q <= crsp_valid_d;
         crsp_err_q   <= crsp_err_d;
         crsp_data_q  <= crsp_data_d;
      end
   end

   assign in_ready         = (state_q == S_FILL);
   assign loaded           = loaded_q;
   assign rreq_ready       = arb_gnt[0];
   assign creq_ready       = arb_gnt[1];
   assign rrsp_valid       = rrsp_valid_q;
   assign rrsp_err         = rrsp_err_q;
   assign rrsp_data        = rrsp_data_q;
   assign crsp_valid       = crsp_valid_q;
   assign crsp_err         = crsp_err_q;
   assign crsp_data        = crsp_data_q;
   assign m_row_addr       = row_addr_q;
   assign m_row_addr_ready = row_ar_q;
   assign m_col_addr       = col_addr_q;
   assign m_col_addr_ready = col_ar_q;
   assign m_write_row_addr = wr_row_q;
   assign m_write_col_addr = wr_col_q;
   assign m_write_data     = wr_data_q;
   assign m_write_ready    = wr_valid_q;

endmodule

// File: tb/tb_matrix_access_ctrl.sv
// Self-checking bench for matrix_access_ctrl: emulates the matrix storage,
// drives fills and row/column requests, and checks against a reference matrix.
module tb_matrix_access_ctrl;

   logic         clk;
   logic         rst_n;
   logic         fill_start;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_data;
   logic         loaded;
   logic         rreq_valid;
   logic         rreq_ready;
   logic [2:0]   rreq_addr;
   logic         rrsp_valid;
   logic         rrsp_err;
   logic [95:0]  rrsp_data;
   logic         creq_valid;
   logic         creq_ready;
   logic [1:0]   creq_addr;
   logic         crsp_valid;
   logic         crsp_err;
   logic [159:0] crsp_data;
   logic [2:0]   m_row_addr;
   logic         m_row_addr_ready;
   logic         m_row_valid;
   logic [95:0]  m_row_out;
   logic [1:0]   m_col_addr;
   logic         m_col_addr_ready;
   logic         m_col_valid;
   logic [159:0] m_col_out;
   logic [2:0]   m_write_row_addr;
   logic [1:0]   m_write_col_addr;
   logic [31:0]  m_write_data;
   logic         m_write_ready;

   matrix_access_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .fill_start       (fill_start),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_data          (in_data),
      .loaded           (loaded),
      .rreq_valid       (rreq_valid),
      .rreq_ready       (rreq_ready),
      .rreq_addr        (rreq_addr),
      .rrsp_valid       (rrsp_valid),
      .rrsp_err         (rrsp_err),
      .rrsp_data        (rrsp_data),
      .creq_valid       (creq_valid),
      .creq_ready       (creq_ready),
      .creq_addr        (creq_addr),
      .crsp_valid       (crsp_valid),
      .crsp_err         (crsp_err),
      .crsp_data        (crsp_data),
      .m_row_addr       (m_row_addr),
      .m_row_addr_ready (m_row_addr_ready),
      .m_row_valid      (m_row_valid),
      .m_row_out        (m_row_out),
      .m_col_addr       (m_col_addr),
      .m_col_addr_ready (m_col_addr_ready),
      .m_col_valid      (m_col_valid),
      .m_col_out        (m_col_out),
      .m_write_row_addr (m_write_row_addr),
      .m_write_col_addr (m_write_col_addr),
      .m_write_data     (m_write_data),
      .m_write_ready    (m_write_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference matrix (what the bench fed in) and emulated storage contents
   logic [31:0] ref_mem [5][3];
   logic [31:0] mem     [5][3];
   bit          pri = 1'b0;          // 0: row wins a tie, 1: column wins a tie

   function automatic logic [159:0] exp_row(input int r);
      logic [159:0] d = '0;
      for (int c = 0; c < 3; c++) d[c*32 +: 32] = ref_mem[r][c];
      return d;
   endfunction

   function automatic logic [159:0] exp_col(input int c);
      logic [159:0] d = '0;
      for (int r = 0; r < 5; r++) d[r*32 +: 32] = ref_mem[r][c];
      return d;
   endfunction

   // Write-port monitor and addr_ready pulse counters, sampled mid-cycle
   typedef struct {
      int          r;
      int          c;
      logic [31:0] d;
   } wr_t;
   wr_t         exp_wr [$];
   wr_t         mon_e;
   int          wr_cnt = 0;
   int          row_ar_cnt = 0;
   int          col_ar_cnt = 0;
   logic [2:0]  last_row_addr = '0;
   logic [1:0]  last_col_addr = '0;

   always @(negedge clk) begin
      if (m_write_ready) begin
         wr_cnt++;
         if (m_write_row_addr < 3'd5 && m_write_col_addr < 2'd3)
            mem[m_write_row_addr][m_write_col_addr] = m_write_data;
         if (exp_wr.size() == 0) begin
            chk("write_spurious", 160'(m_write_ready), 160'(0));
         end else begin
            mon_e = exp_wr.pop_front();
            chk("write_row", 160'(m_write_row_addr), 160'(mon_e.r));
            chk("write_col", 160'(m_write_col_addr), 160'(mon_e.c));
            chk("write_data", 160'(m_write_data), 160'(mon_e.d));
         end
      end
      if (m_row_addr_ready) begin
         row_ar_cnt++;
         last_row_addr = m_row_addr;
      end
      if (m_col_addr_ready) begin
         col_ar_cnt++;
         last_col_addr = m_col_addr;
      end
   end

   // Storage read emulation: junk valid during the addr_ready cycle, then the
   // real data 1..3 cycles later
   logic [2:0]  rs_addr;
   logic [1:0]  cs_addr;
   int unsigned rs_dly;
   int unsigned cs_dly;

   initial begin
      m_row_valid = 1'b0;
      m_row_out   = '0;
      m_col_valid = 1'b0;
      m_col_out   = '0;
   end

   always begin : row_storage
      @(posedge clk);
      #1;
      m_row_valid = 1'b0;
      if (rst_n && m_row_addr_ready) begin
         rs_addr     = m_row_addr;
         m_row_valid = 1'b1;
         m_row_out   = {$urandom, $urandom, $urandom};
         rs_dly      = $urandom_range(1, 3);
         repeat (rs_dly) begin
            @(posedge clk);
            #1;
            m_row_valid = 1'b0;
         end
         m_row_valid = 1'b1;
         if (rs_addr < 3'd5)
            for (int c = 0; c < 3; c++) m_row_out[c*32 +: 32] = mem[rs_addr][c];
      end
   end

   always begin : col_storage
      @(posedge clk);
      #1;
      m_col_valid = 1'b0;
      if (rst_n && m_col_addr_ready) begin
         cs_addr     = m_col_addr;
         m_col_valid = 1'b1;
         m_col_out   = {$urandom, $urandom, $urandom, $urandom, $urandom};
         cs_dly      = $urandom_range(1, 3);
         repeat (cs_dly) begin
            @(posedge clk);
            #1;
            m_col_valid = 1'b0;
         end
         m_col_valid = 1'b1;
         if (cs_addr < 2'd3)
            for (int r = 0; r < 5; r++) m_col_out[r*32 +: 32] = mem[r][cs_addr];
      end
   end

   // Loads n elements (value = linear index unless rand_vals); a full load of
   // 15 also checks loaded timing and the write-pulse count.
   task automatic fill(input int n, input bit rand_vals);
      logic [31:0] v;
      bit          acc;
      bit          loaded_before;
      int          wr_before;
      wr_t         e;
      fill_start = 1'b1;
      tick();
      fill_start = 1'b0;
      wr_before = wr_cnt;
      loaded_before = 1'b0;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         v = rand_vals ? 32'($urandom) : 32'(i);
         in_valid = 1'b1;
         in_data  = v;
         acc = 1'b0;
         for (int k = 0; k < 10 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            loaded_before = loaded;
            tick();
         end
         in_valid = 1'b0;
         chk("fill_accept", 160'(acc), 160'(1));
         ref_mem[i / 3][i % 3] = v;
         e.r = i / 3;
         e.c = i % 3;
         e.d = v;
         exp_wr.push_back(e);
      end
      if (n == 15) begin
         chk("loaded_before_last", 160'(loaded_before), 160'(0));
         chk("loaded_after_last", 160'(loaded), 160'(1));
         tick();
         chk("write_count", 160'(wr_cnt - wr_before), 160'(15));
         chk("write_queue_drained", 160'(exp_wr.size()), 160'(0));
         chk("in_ready_after_fill", 160'(in_ready), 160'(0));
      end
   endtask

   // One request (row, column or both at once) checked end to end.
   task automatic request(input bit want_r, input bit want_c, input logic [2:0] ra,
                          input logic [1:0] ca, input bit poke_fill,
                          output int gnt, output logic err, output logic [159:0] data);
      int exp_gnt;
      int lat;
      int ar_before;
      bit exp_oob;
      gnt  = -1;
      err  = 1'b0;
      data = '0;
      exp_gnt = (want_r && want_c) ? int'(pri) : (want_c ? 1 : 0);
      rreq_valid = want_r;
      rreq_addr  = ra;
      creq_valid = want_c;
      creq_addr  = ca;
      for (int i = 0; i < 20 && gnt < 0; i++) begin
         @(negedge clk);
         if (rreq_ready && creq_ready)
            chk("single_grant", 160'({rreq_ready, creq_ready}), 160'(2'b01));
         if (rreq_ready) gnt = 0;
         else if (creq_ready) gnt = 1;
         tick();
      end
      rreq_valid = 1'b0;
      creq_valid = 1'b0;
      chk("grant_who", 160'(gnt), 160'(exp_gnt));
      if (gnt < 0) return;
      pri = (gnt == 0);
      ar_before = (gnt == 1) ? col_ar_cnt : row_ar_cnt;
      exp_oob = (gnt == 1) ? (ca >= 2'd3) : (ra >= 3'd5);
      if (poke_fill) fill_start = 1'b1;
      lat = 1;
      while (!((gnt == 1) ? crsp_valid : rrsp_valid) && lat < 20) begin
         tick();
         fill_start = 1'b0;
         lat++;
      end
      fill_start = 1'b0;
      err  = (gnt == 1) ? crsp_err : rrsp_err;
      data = (gnt == 1) ? crsp_data : {64'b0, rrsp_data};
      chk("rsp_valid", 160'((gnt == 1) ? crsp_valid : rrsp_valid), 160'(1));
      chk("rsp_err", 160'(err), 160'(exp_oob));
      chk("rsp_data", data,
          exp_oob ? 160'(0) : ((gnt == 1) ? exp_col(int'(ca)) : exp_row(int'(ra))));
      if (exp_oob) chk("oob_latency", 160'(lat), 160'(1));
      else         chk("latency_min3", 160'(lat >= 3), 160'(1));
      tick();
      chk("rsp_one_cycle", 160'((gnt == 1) ? crsp_valid : rrsp_valid), 160'(0));
      chk("addr_ready_pulses",
          160'(((gnt == 1) ? col_ar_cnt : row_ar_cnt) - ar_before), 160'(exp_oob ? 0 : 1));
      if (!exp_oob)
         chk("m_addr", (gnt == 1) ? 160'(last_col_addr) : 160'(last_row_addr),
             (gnt == 1) ? 160'(ca) : 160'(ra));
   endtask

   typedef struct {
      bit           is_col;
      logic [2:0]   addr;
      bit           exp_err;
      logic [159:0] exp_data;
   } vec_t;

   vec_t vecs [9];

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int           g;
      logic         e;
      logic [159:0] d;

      // Element values are r*3+c after the deterministic fill
      vecs[0] = '{1'b0, 3'd0, 1'b0, 160'({32'd2, 32'd1, 32'd0})};
      vecs[1] = '{1'b0, 3'd4, 1'b0, 160'({32'd14, 32'd13, 32'd12})};
      vecs[2] = '{1'b0, 3'd5, 1'b1, 160'(0)};
      vecs[3] = '{1'b0, 3'd7, 1'b1, 160'(0)};
      vecs[4] = '{1'b1, 3'd0, 1'b0, 160'({32'd12, 32'd9, 32'd6, 32'd3, 32'd0})};
      vecs[5] = '{1'b1, 3'd2, 1'b0, 160'({32'd14, 32'd11, 32'd8, 32'd5, 32'd2})};
      vecs[6] = '{1'b1, 3'd3, 1'b1, 160'(0)};
      vecs[7] = '{1'b0, 3'd2, 1'b0, 160'({32'd8, 32'd7, 32'd6})};
      vecs[8] = '{1'b1, 3'd1, 1'b0, 160'({32'd13, 32'd10, 32'd7, 32'd4, 32'd1})};

      rst_n      = 1'b0;
      fill_start = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      rreq_valid = 1'b0;
      rreq_addr  = '0;
      creq_valid = 1'b0;
      creq_addr  = '0;
      repeat (3) tick();

      chk("rst_loaded", 160'(loaded), 160'(0));
      chk("rst_in_ready", 160'(in_ready), 160'(0));
      chk("rst_write_ready", 160'(m_write_ready), 160'(0));
      chk("rst_row_addr_ready", 160'(m_row_addr_ready), 160'(0));
      chk("rst_rsp", 160'({rrsp_valid, rrsp_err, crsp_valid, crsp_err}), 160'(0));
      chk("rst_rsp_data", 160'({rrsp_data, crsp_data}), 160'(0));
      rst_n = 1'b1;
      tick();

      // Requests before any load are never accepted
      rreq_valid = 1'b1;
      creq_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ready_before_load", 160'({rreq_ready, creq_ready}), 160'(0));
         tick();
      end
      rreq_valid = 1'b0;
      creq_valid = 1'b0;

      fill(15, 1'b0);

      foreach (vecs[i]) begin
         request(!vecs[i].is_col, vecs[i].is_col, vecs[i].addr, vecs[i].addr[1:0], 1'b0, g, e, d);
         chk("vec_err", 160'(e), 160'(vecs[i].exp_err));
         chk("vec_data", d, vecs[i].exp_data);
      end

      // Simultaneous requests: last grant was a column, so row goes first
      for (int i = 0; i < 4; i++) begin
         request(1'b1, 1'b1, 3'd2, 2'd0, 1'b0, g, e, d);
         chk("sim_order", 160'(g), 160'(i % 2));
         chk("sim_data", d, (i % 2 == 0) ? 160'({32'd8, 32'd7, 32'd6})
                                         : 160'({32'd12, 32'd9, 32'd6, 32'd3, 32'd0}));
      end

      // fill_start while a row read is outstanding is ignored
      request(1'b1, 1'b0, 3'd3, 2'd0, 1'b1, g, e, d);
      chk("poke_loaded", 160'(loaded), 160'(1));
      chk("poke_in_ready", 160'(in_ready), 160'(0));
      chk("poke_data", d, 160'({32'd11, 32'd10, 32'd9}));
      request(1'b0, 1'b1, 3'd0, 2'd2, 1'b0, g, e, d);

      // Random contents and random request mix
      fill(15, 1'b1);
      for (int i = 0; i < 40; i++) begin
         bit wr;
         bit wc;
         wr = 1'($urandom_range(0, 1));
         wc = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         request(wr, wc, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'b0, g, e, d);
      end

      // Reset in the middle of a fill
      fill(7, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", 160'(in_ready), 160'(0));
      chk("midrst_write_ready", 160'(m_write_ready), 160'(0));
      chk("midrst_loaded", 160'(loaded), 160'(0));
      chk("midrst_rsp_data", 160'({rrsp_data, crsp_data}), 160'(0));
      exp_wr.delete();
      pri = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      rreq_valid = 1'b1;
      #1;
      chk("midrst_ready_gated", 160'(rreq_ready), 160'(0));
      rreq_valid = 1'b0;
      tick();
      fill(15, 1'b1);
      for (int i = 0; i < 8; i++) begin
         bit wr;
         bit wc;
         wr = 1'($urandom_range(0, 1));
         wc = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         request(wr, wc, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'b0, g, e, d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
